pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, synchronous, active-high.
REQ-002 Ports SHALL be exactly:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 id_rs1  in  5  rs1 of instruction in ID
 id_rs2  in  5  rs2 of instruction in ID
 ex_memread  in  1  instruction in EX is a load
 ex_rd  in  5  destination register of instruction in EX
 ex_branch_taken  in  1  branch in EX resolved taken
 mem_req  in  1  instruction in MEM accesses data memory
 mem_ready  in  1  data memory completes access this cycle
 halt_req  in  1  request pipeline drain and halt (level)
 pc_en  out  1  PC update enable
 ifid_en, idex_en, exmem_en  out  1 each  pipeline-register load enables (0 = hold)
 ifid_flush, idex_flush  out  1 each  load bubble (all-zero) at next edge; flush overrides enable
 memwb_bubble  out  1  force MEM/WB control field WB_in to 0 at next edge
 halted  out  1  pipeline drained and halted
 mem_timeout  out  1  sticky: memory wait exceeded limit
 stall_cnt  out  32  stall-cycle performance counter

Function
REQ-003 mem_stall SHALL be mem_req & ~mem_ready; load_use SHALL be ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-004 Control outputs SHALL be combinational from current inputs and state, evaluated in this priority order.
REQ-005 If mem_stall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1; both flushes = 0.
REQ-006 Else if ex_branch_taken: all enables = 1; ifid_flush = idex_flush = 1; memwb_bubble = 0.
REQ-007 Else if load_use: pc_en = ifid_en = 0; idex_en = exmem_en = 1; idex_flush = 1; ifid_flush = 0.
REQ-008 Otherwise: all enables = 1, flushes = 0, memwb_bubble = 0.
REQ-009 A taken branch held in EX during mem_stall SHALL take effect on the first non-stall cycle; no internal latching.
REQ-010 FSM states: RUN, DRAIN, HALTED; register drain_cnt[2:0].
REQ-011 RUN -> DRAIN at the edge where halt_req = 1; drain_cnt cleared.
REQ-012 In DRAIN and HALTED, when neither mem_stall nor load_use holds: pc_en = 0 and ifid_flush = 1 (overrides REQ-006/008 values for these two signals only).
REQ-013 In DRAIN, drain_cnt SHALL increment on each cycle without mem_stall and without load_use; the edge where drain_cnt = 3 and it increments moves FSM to HALTED (4 qualifying cycles).
REQ-014 DRAIN -> RUN at any edge where halt_req = 0; drain_cnt cleared.
REQ-015 HALTED: halted = 1; HALTED -> RUN at edge where halt_req = 0; halted = 0 in RUN and DRAIN.
REQ-016 wait_cnt[7:0] SHALL increment each mem_stall cycle (saturate at 255) and clear on any non-stall cycle.
REQ-017 mem_timeout SHALL set at the edge where mem_stall = 1 and wait_cnt = 255, and stay set until reset.
REQ-018 stall_cnt SHALL increment by 1 each cycle mem_stall | load_use, saturating at 32'hFFFFFFFF.

Reset
REQ-019 With rst = 1 at an edge: state = RUN, drain_cnt = 0, wait_cnt = 0, stall_cnt = 0, mem_timeout = 0.
REQ-020 While rst = 1: pc_en = 0, ifid_flush = idex_flush = memwb_bubble = 1, other enables = 1, halted = 0; reset mid-DRAIN or mid-stall aborts to RUN.

Verification
REQ-021 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt +1. ex_rd=0 -> no stall.
REQ-022 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0, memwb_bubble=1 for 3 cycles, stall_cnt=3, wait_cnt returns 0.
REQ-023 Branch during stall: ex_branch_taken=1 with mem_stall 2 cycles -> no flush during stall; ifid_flush=idex_flush=1 on cycle 3.
REQ-024 Drain: halt_req=1 in RUN, no hazards -> DRAIN 4 cycles with pc_en=0, ifid_flush=1, halted=1 on 5th cycle after edge; halt_req=0 -> RUN next cycle.
REQ-025 Timeout: mem_stall held 260 cycles -> mem_timeout=1 after 256th stall edge, remains 1 after mem_ready; cleared only by rst.
REQ-026 Reset mid-drain: rst=1 with drain_cnt=2 -> state RUN, counters 0, halted=0 after edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble steering, halt-and-drain FSM,
// memory-wait timeout watchdog and stall performance counter.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        halted,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t      state;
    logic [2:0]  drain_cnt;
    logic [7:0]  wait_cnt;
    logic        mem_stall;
    logic        load_use;
    logic        quiet;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_memread & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign quiet     = ~mem_stall & ~load_use;

    // A branch held in EX during a memory stall simply re-presents itself
    // once the stall clears, so no branch state is kept here.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            if (mem_stall) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            // While draining, stop fetching and feed bubbles into ID.
            if (state != RUN && quiet) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            halted = (state == HALTED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= 3'd0;
                    end
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state     <= RUN;
                        drain_cnt <= 3'd0;
                    end else if (quiet) begin
                        if (drain_cnt == 3'd3) begin
                            state     <= HALTED;
                            drain_cnt <= 3'd0;
                        end else begin
                            drain_cnt <= drain_cnt + 3'd1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state     <= RUN;
                    drain_cnt <= 3'd0;
                end
            endcase

            if (mem_stall) begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt == 8'hFF) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end

            if (!quiet && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the DUT outputs.
module tb_pipeline_ctrl;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [6:0] NRM = 7'b1111_000;
    localparam logic [6:0] MST = 7'b0000_001;
    localparam logic [6:0] BRN = 7'b1111_110;
    localparam logic [6:0] LDU = 7'b0011_010;
    localparam logic [6:0] RST = 7'b0111_111;
    localparam logic [6:0] DRN = 7'b0111_100;
    localparam logic [6:0] DBR = 7'b0111_110;

    typedef struct {
        logic [40:0] v;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_branch_taken, mem_req, mem_ready, halt_req;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_bubble, halted, mem_timeout;
    logic [31:0] stall_cnt;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .halt_req       (halt_req),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .memwb_bubble   (memwb_bubble),
        .halted         (halted),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge and hold for the cycle.
    task automatic applyStimulus(input logic r, h, mq, mrdy, br, lm,
                                 input logic [4:0] rd, r1, r2,
                                 input logic [6:0] ctl, input logic hl, tmo,
                                 input logic [31:0] sc, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; halt_req = h; mem_req = mq; mem_ready = mrdy;
        ex_branch_taken = br; ex_memread = lm; ex_rd = rd;
        id_rs1 = r1; id_rs2 = r2;
        e.v   = {ctl, hl, tmo, sc};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [40:0] act;
        act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, halted, mem_timeout, stall_cnt};
        n_cmp++;
        if (act !== e.v) begin
            n_bad++;
            $display("[TB] FAIL %s: got ctl=%b halted=%b to=%b sc=%0d, want ctl=%b halted=%b to=%b sc=%0d",
                     e.tag, act[40:34], act[33], act[32], act[31:0],
                     e.v[40:34], e.v[33], e.v[32], e.v[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; halt_req = 0; mem_req = 0; mem_ready = 0;
        ex_branch_taken = 0; ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        repeat (2) @(posedge clk);

        // r  h  mq rdy br lm rd  r1  r2   ctl  hl to sc
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 2, RST, 0, 0, 0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 0, "idle");
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 1, 5, LDU, 0, 0, 0, "lu_rs2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 1, "after_lu");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, NRM, 0, 0, 1, "lu_rd0");
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 7, 2, LDU, 0, 0, 1, "lu_rs1");
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 7, 2, NRM, 0, 0, 2, "no_load");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, 0, 2, "mwait1");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, 0, 3, "mwait2");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, 0, 4, "mwait3");
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 2, NRM, 0, 0, 5, "mready");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 5, "idle2");
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1, 2, MST, 0, 0, 5, "br_stall1");
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1, 2, MST, 0, 0, 6, "br_stall2");
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 1, 2, BRN, 0, 0, 7, "br_release");
        applyStimulus(0, 0, 0, 0, 1, 1, 5, 5, 2, BRN, 0, 0, 7, "br_over_lu");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 8, "idle3");
        applyStimulus(0, 0, 1, 0, 0, 1, 5, 5, 2, MST, 0, 0, 8, "mst_over_lu");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 9, "idle4");

        // Drain with interleaved hazards that must not count
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 9,  "halt_run");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 9,  "drain_q1");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 2, MST, 0, 0, 9,  "drain_mst");
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 5, 2, LDU, 0, 0, 10, "drain_lu");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "drain_q2");
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 1, 2, DBR, 0, 0, 11, "drain_q3_br");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "drain_q4");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 1, 0, 11, "halted1");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 1, 0, 11, "halted2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, DRN, 1, 0, 11, "unhalt");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 11, "run_again");

        // Drain aborted by dropping halt_req
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 11, "halt_run2");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "abort_q1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "abort");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 11, "aborted_run");

        // Reset mid-drain, then a clean 4-cycle drain
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 11, "halt_run3");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "rd_q1");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 11, "rd_q2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 2, RST, 0, 0, 11, "rst_in_drain");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 0,  "post_rst_run");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 0, 0, 0, "clean_drain");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2, DRN, 1, 0, 0, "clean_halted");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, DRN, 1, 0, 0, "clean_unhalt");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 0, "clean_run");

        // Wait counter must clear on a ready cycle before the long stall
        for (int i = 0; i < 200; i++)
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, 0, 32'(i), "mwait_pre");
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 2, NRM, 0, 0, 200, "mwait_clear");
        for (int j = 0; j < 260; j++)
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, (j >= 256),
                          32'(200 + j), "timeout_run");
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 2, NRM, 0, 1, 460, "timeout_sticky1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 1, 460, "timeout_sticky2");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 2, MST, 0, 1, 460, "stall_pre_rst");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 2, RST, 0, 1, 461, "rst_in_stall");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, NRM, 0, 0, 0,   "timeout_cleared");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
